// File: rtl/mux_key_with_default_reg.sv
// Keyed lookup mux with default value, followed by a write-enabled holding register.
// Combinational result on out/hit; registered copy on q.
module mux_key_with_default_reg #(
   parameter int unsigned             NR_KEY    = 2,
   parameter int unsigned             KEY_LEN   = 1,
   parameter int unsigned             DATA_LEN  = 1,
   parameter logic [DATA_LEN-1:0]     RESET_VAL = '0
) (
   input  logic                                    clock,
   input  logic                                    reset,
   input  logic [KEY_LEN-1:0]                      key,
   input  logic [DATA_LEN-1:0]                     default_out,
   input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]    lut,
   input  logic                                    wen,
   output logic [DATA_LEN-1:0]                     out,
   output logic                                    hit,
   output logic [DATA_LEN-1:0]                     q
);

   localparam int unsigned P = KEY_LEN + DATA_LEN;

   logic [P-1:0]        entry_w;
   logic [DATA_LEN-1:0] sel_w;
   logic                hit_w;
   logic [DATA_LEN-1:0] q_d;
   logic [DATA_LEN-1:0] q_q;

   // Entry 0 sits in the most-significant pair; duplicate matches OR together.
   always_comb begin
      entry_w = '0;
      sel_w   = '0;
      hit_w   = 1'b0;
      for (int unsigned i = 0; i < NR_KEY; i++) begin
         entry_w = lut[(NR_KEY-1-i)*P +: P];
         if (entry_w[P-1 -: KEY_LEN] == key) begin
            hit_w = 1'b1;
            sel_w = sel_w | entry_w[DATA_LEN-1:0];
         end
      end
   end

   assign out = hit_w ? sel_w : default_out;
   assign hit = hit_w;

   always_comb begin
      q_d = q_q;
      if (wen) q_d = out;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) q_q <= RESET_VAL;
      else        q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: tb/tb_mux_key_with_default_reg.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor
// pops and compares them against the relevant DUT instance.
module tb_mux_key_with_default_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // u0: write-back select, NR_KEY=4 KEY_LEN=2 DATA_LEN=32
   logic [1:0]   key0;
   logic [31:0]  def0, out0, q0;
   logic [135:0] lut0;
   logic         hit0, wen0, rst0;
   // u1: default path, NR_KEY=3 KEY_LEN=32 DATA_LEN=32
   logic [31:0]  key1, def1, out1, q1;
   logic [191:0] lut1;
   logic         hit1, wen1, rst1;
   // u2: duplicate keys, NR_KEY=2 KEY_LEN=1 DATA_LEN=8
   logic         key2, hit2, wen2, rst2;
   logic [7:0]   def2, out2, q2;
   logic [17:0]  lut2;
   // u3: register enable, RESET_VAL=0
   logic         key3, hit3, wen3, rst3;
   logic [31:0]  def3, out3, q3;
   logic [32:0]  lut3;
   // u4: async reset mid-run, RESET_VAL=80000000
   logic         key4, hit4, wen4, rst4;
   logic [31:0]  def4, out4, q4;
   logic [32:0]  lut4;

   mux_key_with_default_reg #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(32), .RESET_VAL(32'h0)) u0 (
      .clock(clk), .reset(rst0), .key(key0), .default_out(def0), .lut(lut0),
      .wen(wen0), .out(out0), .hit(hit0), .q(q0));
   mux_key_with_default_reg #(.NR_KEY(3), .KEY_LEN(32), .DATA_LEN(32), .RESET_VAL(32'h0)) u1 (
      .clock(clk), .reset(rst1), .key(key1), .default_out(def1), .lut(lut1),
      .wen(wen1), .out(out1), .hit(hit1), .q(q1));
   mux_key_with_default_reg #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(8), .RESET_VAL(8'h0)) u2 (
      .clock(clk), .reset(rst2), .key(key2), .default_out(def2), .lut(lut2),
      .wen(wen2), .out(out2), .hit(hit2), .q(q2));
   mux_key_with_default_reg #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(32), .RESET_VAL(32'h0)) u3 (
      .clock(clk), .reset(rst3), .key(key3), .default_out(def3), .lut(lut3),
      .wen(wen3), .out(out3), .hit(hit3), .q(q3));
   mux_key_with_default_reg #(.NR_KEY(1), .KEY_LEN(1), .DATA_LEN(32), .RESET_VAL(32'h80000000)) u4 (
      .clock(clk), .reset(rst4), .key(key4), .default_out(def4), .lut(lut4),
      .wen(wen4), .out(out4), .hit(hit4), .q(q4));

   typedef struct {
      int          id;
      string       name;
      bit          chk_comb;
      logic [31:0] exp_out;
      logic        exp_hit;
      bit          chk_q;
      logic [31:0] exp_q;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic push(input int id, input string name, input bit cc, input logic [31:0] eo,
                       input logic eh, input bit cq, input logic [31:0] eq);
      exp_t e;
      e.id = id; e.name = name; e.chk_comb = cc; e.exp_out = eo;
      e.exp_hit = eh; e.chk_q = cq; e.exp_q = eq;
      sb.push_back(e);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: outputs are compared mid-cycle, away from the rising edge.
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         exp_t        e;
         logic [31:0] a_out, a_q;
         logic        a_hit;
         e = sb.pop_front();
         a_out = '0; a_q = '0; a_hit = 1'b0;
         case (e.id)
            0: begin a_out = out0;          a_hit = hit0; a_q = q0;          end
            1: begin a_out = out1;          a_hit = hit1; a_q = q1;          end
            2: begin a_out = {24'h0, out2}; a_hit = hit2; a_q = {24'h0, q2}; end
            3: begin a_out = out3;          a_hit = hit3; a_q = q3;          end
            default: begin a_out = out4;    a_hit = hit4; a_q = q4;          end
         endcase
         if (e.chk_comb) begin
            total++;
            if (a_out !== e.exp_out || a_hit !== e.exp_hit) begin
               bad++;
               $display("FAIL %s: out=%h hit=%b, expected out=%h hit=%b",
                        e.name, a_out, a_hit, e.exp_out, e.exp_hit);
            end
         end
         if (e.chk_q) begin
            total++;
            if (a_q !== e.exp_q) begin
               bad++;
               $display("FAIL %s: q=%h, expected q=%h", e.name, a_q, e.exp_q);
            end
         end
      end
   end

   initial begin
      logic [31:0] wb_exp [4];
      wb_exp[0] = 32'h11; wb_exp[1] = 32'h22; wb_exp[2] = 32'h33; wb_exp[3] = 32'h44;

      rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b1; rst4 = 1'b0;
      wen0 = 1'b0; wen1 = 1'b0; wen2 = 1'b0; wen3 = 1'b0; wen4 = 1'b0;
      key0 = '0; def0 = 32'hFFFFFFFF;
      lut0 = {2'b00, 32'h11, 2'b01, 32'h22, 2'b10, 32'h33, 2'b11, 32'h44};
      key1 = '0; def1 = '0;
      lut1 = {32'h000000ff, 32'hAAAA0001, 32'h0000ffff, 32'hBBBB0002, 32'hffffffff, 32'hCCCC0003};
      key2 = 1'b1; def2 = 8'h5A;
      lut2 = {1'b1, 8'h0F, 1'b1, 8'hF0};
      key3 = 1'b1; def3 = '0; lut3 = {1'b1, 32'hA00003F8};
      key4 = 1'b1; def4 = '0; lut4 = {1'b1, 32'h00000005};

      next_cycle();
      rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;

      // Write-back select: every key hits its own entry
      for (int k = 0; k < 4; k++) begin
         next_cycle();
         key0 = 2'(k);
         push(0, $sformatf("wb_sel_key%0d", k), 1'b1, wb_exp[k], 1'b1, 1'b0, '0);
      end

      // Default path
      next_cycle();
      key1 = 32'h00000f00; def1 = 32'h0;
      push(1, "default_zero", 1'b1, 32'h0, 1'b0, 1'b0, '0);
      next_cycle();
      def1 = 32'hDEADBEEF;
      push(1, "default_value", 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, '0);
      next_cycle();
      key1 = 32'h0000ffff;
      push(1, "key_entry1", 1'b1, 32'hBBBB0002, 1'b1, 1'b0, '0);
      next_cycle();
      key1 = 32'hffffffff;
      push(1, "key_entry2_last", 1'b1, 32'hCCCC0003, 1'b1, 1'b0, '0);
      next_cycle();
      key1 = 32'h000000ff;
      push(1, "key_entry0_first", 1'b1, 32'hAAAA0001, 1'b1, 1'b0, '0);

      // Duplicate keys OR their data
      next_cycle();
      key2 = 1'b1;
      push(2, "dup_keys_or", 1'b1, 32'hFF, 1'b1, 1'b0, '0);
      next_cycle();
      key2 = 1'b0;
      push(2, "dup_no_hit", 1'b1, 32'h5A, 1'b0, 1'b0, '0);

      // Register enable: async reset, capture, hold
      next_cycle();
      rst3 = 1'b0;
      push(3, "reg_async_reset", 1'b0, '0, 1'b0, 1'b1, 32'h0);
      next_cycle();
      rst3 = 1'b1; key3 = 1'b1; wen3 = 1'b1;
      push(3, "reg_pre_capture", 1'b1, 32'hA00003F8, 1'b1, 1'b1, 32'h0);
      next_cycle();
      wen3 = 1'b0; key3 = 1'b0; def3 = 32'h12345678;
      push(3, "reg_capture", 1'b1, 32'h12345678, 1'b0, 1'b1, 32'hA00003F8);
      next_cycle();
      def3 = 32'h0BADF00D;
      push(3, "reg_hold", 1'b0, '0, 1'b0, 1'b1, 32'hA00003F8);

      // Async reset mid-run with non-zero RESET_VAL
      next_cycle();
      rst4 = 1'b1; wen4 = 1'b1; key4 = 1'b1;
      push(4, "rv_after_reset", 1'b0, '0, 1'b0, 1'b1, 32'h80000000);
      next_cycle();
      push(4, "rv_load5", 1'b0, '0, 1'b0, 1'b1, 32'h5);
      next_cycle();
      rst4 = 1'b0; key4 = 1'b0; def4 = 32'h77;
      push(4, "rv_async_mid", 1'b1, 32'h77, 1'b0, 1'b1, 32'h80000000);
      next_cycle();
      push(4, "rv_wen_ignored", 1'b0, '0, 1'b0, 1'b1, 32'h80000000);
      next_cycle();
      rst4 = 1'b1;
      push(4, "rv_released_no_edge", 1'b0, '0, 1'b0, 1'b1, 32'h80000000);
      next_cycle();
      wen4 = 1'b0;
      push(4, "rv_first_capture", 1'b0, '0, 1'b0, 1'b1, 32'h77);

      // Drain scoreboard with a bounded wait
      for (int w = 0; w < 20 && sb.size() > 0; w++) @(posedge clk);
      if (sb.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: pending=%0d, expected pending=0", sb.size());
      end
      @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
